// File: rtl/minibus_sram_slave_if.sv
// Minibus request/response bundle between the address decoder and one slave endpoint.
// The decoder-facing side is the master; the SRAM endpoint uses the slave modport.
interface minibus_sram_slave_if;
  logic        sel;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strobe;
  logic [31:0] res_rdata;
  logic        res_ready;
  logic        res_error;

  modport master (
    output sel, req_ren, req_wen, req_addr, req_wdata, req_strobe,
    input  res_rdata, res_ready, res_error
  );

  modport slave (
    input  sel, req_ren, req_wen, req_addr, req_wdata, req_strobe,
    output res_rdata, res_ready, res_error
  );
endinterface

// File: rtl/minibus_sram_slave.sv
// Minibus SRAM slave: word-organised memory with WAIT_CYCLES of programmable latency.
// Latency: request sampled in IDLE at cycle N -> one-cycle ready pulse in cycle N+WAIT_CYCLES+1.
module minibus_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  minibus_sram_slave_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp;

  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_strobe;
  logic        lat_ren, lat_wen;

  logic [31:0] res_rdata_q;
  logic        res_ready_q, res_error_q;

  logic [31:0] mem [DEPTH];

  logic        valid;
  logic [31:0] cur_addr, cur_wdata, offset;
  logic [3:0]  cur_strobe;
  logic        cur_ren, cur_wen, req_err, wr_en;
  logic [AW-1:0] idx;

  assign valid = bus.sel & (bus.req_ren | bus.req_wen);

  // With zero wait cycles the response is formed on the capture edge, so IDLE uses live inputs.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_addr   = bus.req_addr;
      cur_wdata  = bus.req_wdata;
      cur_strobe = bus.req_strobe;
      cur_ren    = bus.req_ren;
      cur_wen    = bus.req_wen;
    end else begin
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
      cur_strobe = lat_strobe;
      cur_ren    = lat_ren;
      cur_wen    = lat_wen;
    end
  end

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign offset  = cur_addr - BASE_ADDR;
  assign idx     = offset[AW+1:2];
  assign req_err = (cur_ren & cur_wen) | (cur_addr[1:0] != 2'b00) | (offset >= SPAN);
  assign wr_en   = nRST & enter_resp & cur_wen & ~req_err;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      lat_addr    <= 32'h0;
      lat_wdata   <= 32'h0;
      lat_strobe  <= 4'h0;
      lat_ren     <= 1'b0;
      lat_wen     <= 1'b0;
      res_ready_q <= 1'b0;
      res_error_q <= 1'b0;
      res_rdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE && valid) begin
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
        lat_strobe <= bus.req_strobe;
        lat_ren    <= bus.req_ren;
        lat_wen    <= bus.req_wen;
      end
      if (enter_resp) begin
        res_ready_q <= 1'b1;
        res_error_q <= req_err;
        res_rdata_q <= (cur_ren && !req_err) ? mem[idx] : 32'h0;
      end else begin
        res_ready_q <= 1'b0;
        res_error_q <= 1'b0;
        res_rdata_q <= 32'h0;
      end
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_strobe[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign bus.res_ready = res_ready_q;
  assign bus.res_error = res_error_q;
  assign bus.res_rdata = res_rdata_q;

endmodule

// File: tb/tb_minibus_sram_slave.sv
// Directed bench for minibus_sram_slave: one instance with two wait cycles, one with none.
module tb_minibus_sram_slave;

  logic        clk = 1'b0;
  logic        nrst;
  logic        use_w0;
  logic        drv_sel, drv_ren, drv_wen;
  logic [31:0] drv_addr, drv_wdata;
  logic [3:0]  drv_strobe;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  minibus_sram_slave_if bus2 ();
  minibus_sram_slave_if bus0 ();

  assign bus2.sel        = drv_sel & ~use_w0;
  assign bus2.req_ren    = drv_ren;
  assign bus2.req_wen    = drv_wen;
  assign bus2.req_addr   = drv_addr;
  assign bus2.req_wdata  = drv_wdata;
  assign bus2.req_strobe = drv_strobe;
  assign bus0.sel        = drv_sel & use_w0;
  assign bus0.req_ren    = drv_ren;
  assign bus0.req_wen    = drv_wen;
  assign bus0.req_addr   = drv_addr;
  assign bus0.req_wdata  = drv_wdata;
  assign bus0.req_strobe = drv_strobe;

  minibus_sram_slave #(.BASE_ADDR(32'h1000_0000), .DEPTH(256), .WAIT_CYCLES(2)) dut (
    .CLK(clk), .nRST(nrst), .bus(bus2)
  );

  minibus_sram_slave #(.BASE_ADDR(32'h1000_0000), .DEPTH(256), .WAIT_CYCLES(0)) dut_w0 (
    .CLK(clk), .nRST(nrst), .bus(bus0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drop_req();
    drv_sel    = 1'b0;
    drv_ren    = 1'b0;
    drv_wen    = 1'b0;
    drv_addr   = 32'h0;
    drv_wdata  = 32'h0;
    drv_strobe = 4'h0;
  endtask

  // Called just after a rising edge; that cycle is cycle 0. Observes cycles 0..8 at the falling edge.
  task automatic txn(input string tag, input logic w0, input logic ren, input logic wen,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     input int hold, input int rst_cyc, input logic [7:0] mask,
                     input logic exp_err, input logic [31:0] exp_rdata);
    logic        e_rdy;
    logic        g_rdy, g_err;
    logic [31:0] g_rd;
    use_w0     = w0;
    drv_sel    = 1'b1;
    drv_ren    = ren;
    drv_wen    = wen;
    drv_addr   = addr;
    drv_wdata  = wdata;
    drv_strobe = strb;
    for (int c = 0; c < 9; c++) begin
      if (c == rst_cyc) nrst = 1'b0;
      @(negedge clk);
      e_rdy = (c < 8) ? mask[c] : 1'b0;
      g_rdy = w0 ? bus0.res_ready : bus2.res_ready;
      g_err = w0 ? bus0.res_error : bus2.res_error;
      g_rd  = w0 ? bus0.res_rdata : bus2.res_rdata;
      check($sformatf("%s c%0d ready", tag, c), {31'h0, g_rdy}, {31'h0, e_rdy});
      check($sformatf("%s c%0d error", tag, c), {31'h0, g_err}, {31'h0, e_rdy & exp_err});
      check($sformatf("%s c%0d rdata", tag, c), g_rd, e_rdy ? exp_rdata : 32'h0);
      if (c == rst_cyc) nrst = 1'b1;
      @(posedge clk);
      #1;
      if (c + 1 == hold) drop_req();
    end
  endtask

  initial begin
    use_w0 = 1'b0;
    drop_req();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", {31'h0, bus2.res_ready}, 32'h0);
    check("reset error", {31'h0, bus2.res_error}, 32'h0);
    check("reset rdata", bus2.res_rdata, 32'h0);
    check("reset w0 ready", {31'h0, bus0.res_ready}, 32'h0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    txn("wr full",    1'b0, 1'b0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1, -1, 8'b0000_1000, 1'b0, 32'h0);
    txn("rd full",    1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b0, 32'hDEAD_BEEF);
    txn("wr lane1",   1'b0, 1'b0, 1'b1, 32'h1000_0010, 32'h0000_AA00, 4'b0010, 1, -1, 8'b0000_1000, 1'b0, 32'h0);
    txn("rd merged",  1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b0, 32'hDEAD_AAEF);
    txn("rd oor",     1'b0, 1'b1, 1'b0, 32'h1000_0400, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b1, 32'h0);
    txn("rd misalgn", 1'b0, 1'b1, 1'b0, 32'h1000_0002, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b1, 32'h0);
    txn("rd below",   1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b1, 32'h0);
    txn("wr last",    1'b0, 1'b0, 1'b1, 32'h1000_03FC, 32'h0BAD_CAFE, 4'hF, 1, -1, 8'b0000_1000, 1'b0, 32'h0);
    txn("rd last",    1'b0, 1'b1, 1'b0, 32'h1000_03FC, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b0, 32'h0BAD_CAFE);
    txn("rd+wr",      1'b0, 1'b1, 1'b1, 32'h1000_0010, 32'h1234_5678, 4'hF, 1, -1, 8'b0000_1000, 1'b1, 32'h0);
    txn("rd after rw",1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b0, 32'hDEAD_AAEF);
    txn("wr strb0",   1'b0, 1'b0, 1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'h0, 1, -1, 8'b0000_1000, 1'b0, 32'h0);
    txn("rd strb0",   1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b0, 32'hDEAD_AAEF);
    txn("wr reset",   1'b0, 1'b0, 1'b1, 32'h1000_0010, 32'h5555_5555, 4'hF, 1, 2,  8'b0000_0000, 1'b0, 32'h0);
    txn("rd post rst",1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'h0, 1, -1, 8'b0000_1000, 1'b0, 32'hDEAD_AAEF);
    txn("rd held",    1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'h0, 8, -1, 8'b1000_1000, 1'b0, 32'hDEAD_AAEF);
    txn("w0 wr",      1'b1, 1'b0, 1'b1, 32'h1000_0020, 32'hCAFE_F00D, 4'hF, 1, -1, 8'b0000_0010, 1'b0, 32'h0);
    txn("w0 rd held", 1'b1, 1'b1, 1'b0, 32'h1000_0020, 32'h0,         4'h0, 8, -1, 8'b1010_1010, 1'b0, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
